spi_ram_master: RTL
===================

// Module: spi_ram_master
// PURPOSE
//  SPI master that drives the MOSI/MISO/SS_n pins of the SPI-slave + single-port-RAM subsystem.
//  Turns one host request (write byte / read byte at an 8-bit address) into two back-to-back 10-bit SPI frames.
//  Sits directly upstream of the slave, on the same clk; one bit is transferred per clk cycle.
// PARAMETERS
//  FRAME_GAP      1  SS_n-high cycles after every frame (>=1)
//  RD_TURNAROUND  2  cycles SS_n stays low after the last RD_DATA bit before the first MISO sample (>=1)
// PORTS
//  clk        in   1  single clock; all logic on rising edge
//  rst_n      in   1  synchronous reset, active low
//  req_valid  in   1  host request strobe
//  req_ready  out  1  high only in IDLE; a request is accepted on req_valid&&req_ready
//  req_write  in   1  1=write, 0=read
//  req_addr   in   8  RAM address
//  req_wdata  in   8  write data (ignored for reads)
//  rsp_valid  out  1  one-cycle completion pulse for every accepted request
//  rsp_rdata  out  8  last read byte; updated only by reads, held otherwise
//  busy       out  1  ~req_ready
//  MOSI       out  1  serial data to slave, MSB first
//  MISO       in   1  serial data from slave, MSB first
//  SS_n       out  1  slave select, active low
// BEHAVIOUR
//  Reset values (next edge with rst_n=0): SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=8'h00, state=IDLE.
//  Reset mid-frame: SS_n=1 on that edge, request dropped, no rsp_valid.
//  Frame word = {cmd[1:0], payload[7:0]}. cmd: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA (payload 8'h00).
//  Write = WR_ADDR(addr), then WR_DATA(wdata). Read = RD_ADDR(addr), then RD_DATA.
//  Request fields are latched at acceptance; later changes on req_* are ignored.
//  FSM: IDLE -> SEL -> SHIFT -> [TURN -> RECV] -> GAP -> (SEL of frame 2 | IDLE)
//   IDLE : SS_n=1, MOSI=0, req_ready=1; on accept -> SEL, frame index=0.
//   SEL  : 1 cycle, SS_n=0, MOSI=word[9] (command-select bit).
//   SHIFT: 10 cycles, SS_n=0, MOSI=word[9]..word[0]; 4-bit down counter 9..0.
//          After bit 0: RD_DATA frame -> TURN, else -> GAP.
//   TURN : RD_TURNAROUND cycles, SS_n=0, MOSI=0.
//   RECV : 8 cycles, SS_n=0, MOSI=0; MISO sampled at the closing edge of each cycle, shifted in MSB first.
//          rsp_rdata is loaded on the edge that samples bit 0.
//   GAP  : FRAME_GAP cycles, SS_n=1, MOSI=0.
//          After frame 0: -> SEL for frame 1.
//          After frame 1: rsp_valid=1 in the first GAP cycle; -> IDLE at GAP end.
//  Timing (request accepted at edge T, FRAME_GAP=1, RD_TURNAROUND=2):
//   write: SS_n low T+1..T+11 and T+13..T+23; rsp_valid at T+24; req_ready=1 at T+25.
//   read : second frame SS_n low T+13..T+33; MISO bits in T+26..T+33; rsp_valid at T+34.
//  Back-to-back: req_valid held during busy is not accepted until req_ready=1; no request queueing.
//  MISO is ignored outside RECV. MOSI is forced to 0 whenever SS_n=1.
// STRUCTURE
//  Package spi_ram_pkg: CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA (2-bit), FRAME_W=10, DATA_W=8,
//   FSM state encodings; shared with the slave and its testbench.
//  Sub-module spi_frame_shifter: 10-bit parallel-in/serial-out plus 8-bit serial-in/parallel-out with bit counter.
//   Top level holds the transaction FSM and frame index.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles with random inputs -> SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
//  2 Write addr 8'h3C data 8'hA5 -> frame 1 MOSI 0,0,0,0,0,1,1,1,1,0,0; frame 2 MOSI 0,0,1,1,0,1,0,0,1,0,1;
//    one SS_n-high gap between frames; rsp_valid at T+24.
//  3 Read addr 8'h3C, MISO model drives 8'h5A starting 2 cycles after the last RD_DATA bit
//    -> rsp_rdata=8'h5A and rsp_valid at T+34.
//  4 Loopback with the full SPI-slave+RAM system: write 0xA5@0x3C, write 0x11@0xFF, read 0x3C -> 0xA5,
//    read 0xFF -> 0x11.
//  5 req_valid held high with changing req_addr during a busy write -> single accept per IDLE visit;
//    second request uses the address present at its own accept edge.
//  6 Assert rst_n=0 at the 5th SHIFT cycle of a read -> SS_n=1 at the next edge, no rsp_valid;
//    a new write afterwards completes normally.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI master / SPI slave / single-port RAM subsystem.
//  - 2-bit frame commands (top two bits of every 10-bit frame word)
//  - frame and data widths
//  - transaction FSM state encoding of the master
//  - make_word(): packs {cmd, payload} into a frame word
// -----------------------------------------------------------------------------
package spi_ram_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEL   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TURN  = 3'd3,
      ST_RECV  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   function automatic logic [FRAME_W-1:0] make_word(input logic [1:0]        cmd,
                                                    input logic [DATA_W-1:0] payload);
      return {cmd, payload};
   endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// -----------------------------------------------------------------------------
// spi_frame_shifter
// Datapath of the SPI master: a 10-bit parallel-in/serial-out transmit register,
// an 8-bit serial-in/parallel-out receive register and one shared bit counter
// (only one direction is active at a time).
// Ports:
//  clk, rst_n   clock, synchronous active-low reset
//  tx_load      load tx_word, counter := FRAME_W-1
//  tx_word      frame word {cmd, payload}
//  tx_shift     shift transmit register left by one, counter - 1
//  rx_start     counter := DATA_W-1 (start of a receive burst)
//  rx_shift     shift miso into the receive register, counter - 1
//  miso         serial input
//  tx_bit       current transmit bit (register MSB)
//  bit_cnt      shared bit counter, 0 marks the last bit
//  rx_next      receive register value including the bit sampled this cycle
// -----------------------------------------------------------------------------
module spi_frame_shifter
   import spi_ram_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tx_load,
   input  logic [FRAME_W-1:0] tx_word,
   input  logic               tx_shift,
   input  logic               rx_start,
   input  logic               rx_shift,
   input  logic               miso,
   output logic               tx_bit,
   output logic [3:0]         bit_cnt,
   output logic [DATA_W-1:0]  rx_next
);

   logic [FRAME_W-1:0] tx_sreg;
   logic [DATA_W-1:0]  rx_sreg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_sreg <= '0;
         rx_sreg <= '0;
         bit_cnt <= 4'd0;
      end else if (tx_load) begin
         tx_sreg <= tx_word;
         bit_cnt <= 4'(FRAME_W - 1);
      end else if (tx_shift) begin
         tx_sreg <= {tx_sreg[FRAME_W-2:0], 1'b0};
         bit_cnt <= bit_cnt - 4'd1;
      end else if (rx_start) begin
         bit_cnt <= 4'(DATA_W - 1);
      end else if (rx_shift) begin
         rx_sreg <= rx_next;
         bit_cnt <= bit_cnt - 4'd1;
      end
   end

   assign tx_bit  = tx_sreg[FRAME_W-1];
   // Exposing the not-yet-registered byte lets the top capture the full byte
   // on the very edge that samples bit 0.
   assign rx_next = {rx_sreg[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
// SPI master for the SPI-slave + single-port-RAM subsystem. Each host request
// becomes two back-to-back 10-bit frames {cmd, payload}, one bit per clk:
//   write: WR_ADDR(addr), WR_DATA(wdata)    read: RD_ADDR(addr), RD_DATA + 8 MISO bits
// Frame sequence: SEL (1) -> SHIFT (10) -> [TURN (RD_TURNAROUND) -> RECV (8)] -> GAP (FRAME_GAP)
//
// Handshake: a request is accepted on the rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, request fields are captured at that edge and
// later req_* changes are ignored. rsp_valid pulses for one cycle (first GAP
// cycle of the second frame) for every accepted request; no queueing.
//
// Ports:
//  clk, rst_n              clock, synchronous active-low reset
//  req_valid/req_ready     request handshake
//  req_write               1 = write, 0 = read
//  req_addr, req_wdata     RAM address, write data
//  rsp_valid               one-cycle completion pulse
//  rsp_rdata               last read byte, held across writes
//  busy                    ~req_ready
//  MOSI, MISO, SS_n        SPI pins (MSB first, SS_n active low)
//  dbg_state               current FSM state
// -----------------------------------------------------------------------------
module spi_ram_master
   import spi_ram_pkg::*;
#(
   parameter int FRAME_GAP     = 1,
   parameter int RD_TURNAROUND = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              MOSI,
   input  logic              MISO,
   output logic              SS_n,
   output state_t            dbg_state
);

   localparam logic [7:0] GAP_LAST  = 8'(FRAME_GAP - 1);
   localparam logic [7:0] TURN_LAST = 8'(RD_TURNAROUND - 1);

   state_t state, next_state;

   logic              frame_idx;   // 0 = address frame, 1 = data frame
   logic              is_write;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [7:0]        wait_cnt;    // cycles spent in TURN / GAP

   logic               tx_load;
   logic               tx_shift;
   logic               rx_start;
   logic               rx_shift;
   logic               rx_commit;
   logic [FRAME_W-1:0] tx_word;
   logic               tx_bit;
   logic [3:0]         bit_cnt;
   logic [DATA_W-1:0]  rx_next;

   // The first frame is loaded on the accept edge, before the request
   // registers hold anything, so it is built from the live request inputs.
   always_comb begin
      tx_word = '0;
      if (state == ST_IDLE) begin
         tx_word = make_word(req_write ? CMD_WR_ADDR : CMD_RD_ADDR, req_addr);
      end else if (is_write) begin
         tx_word = make_word(CMD_WR_DATA, wdata_q);
      end else begin
         tx_word = make_word(CMD_RD_DATA, '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      rx_start   = 1'b0;
      rx_shift   = 1'b0;
      rx_commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               next_state = ST_SEL;
               tx_load    = 1'b1;
            end
         end
         ST_SEL: begin
            next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            tx_shift = 1'b1;
            if (bit_cnt == 4'd0) begin
               next_state = (frame_idx && !is_write) ? ST_TURN : ST_GAP;
            end
         end
         ST_TURN: begin
            if (wait_cnt == TURN_LAST) begin
               next_state = ST_RECV;
               rx_start   = 1'b1;
            end
         end
         ST_RECV: begin
            rx_shift = 1'b1;
            if (bit_cnt == 4'd0) begin
               next_state = ST_GAP;
               rx_commit  = 1'b1;
            end
         end
         ST_GAP: begin
            if (wait_cnt == GAP_LAST) begin
               if (!frame_idx) begin
                  next_state = ST_SEL;
                  tx_load    = 1'b1;
               end else begin
                  next_state = ST_IDLE;
               end
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_idx <= 1'b0;
         is_write  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wait_cnt  <= 8'd0;
         rsp_rdata <= '0;
      end else begin
         if (state == ST_IDLE && req_valid) begin
            frame_idx <= 1'b0;
            is_write  <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
         end
         if (state == ST_GAP && next_state == ST_SEL) begin
            frame_idx <= 1'b1;
         end
         // Restart on every state change so TURN and GAP each count from 0.
         if (next_state != state) begin
            wait_cnt <= 8'd0;
         end else if (state == ST_TURN || state == ST_GAP) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (rx_commit) begin
            rsp_rdata <= rx_next;
         end
      end
   end

   spi_frame_shifter u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_load  (tx_load),
      .tx_word  (tx_word),
      .tx_shift (tx_shift),
      .rx_start (rx_start),
      .rx_shift (rx_shift),
      .miso     (MISO),
      .tx_bit   (tx_bit),
      .bit_cnt  (bit_cnt),
      .rx_next  (rx_next)
   );

   // addr_q is kept for debug visibility of the accepted request.
   logic unused_addr;
   assign unused_addr = ^addr_q;

   assign req_ready = (state == ST_IDLE);
   assign busy      = ~req_ready;
   assign SS_n      = (state == ST_IDLE) || (state == ST_GAP);
   assign MOSI      = (state == ST_SEL || state == ST_SHIFT) ? tx_bit : 1'b0;
   assign rsp_valid = (state == ST_GAP) && frame_idx && (wait_cnt == 8'd0);
   assign dbg_state = state;

endmodule
